// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared processor constants, field positions and fetch state encoding
package proc_pkg;

    localparam int          PC_W_DEF     = 16;
    localparam int          INSTR_W_DEF  = 16;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;

    localparam int OPC_HI   = 15;
    localparam int OPC_LO   = 12;
    localparam int FUNCT_HI = 3;
    localparam int FUNCT_LO = 0;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_LW    = 4'h1;
    localparam logic [3:0] OP_SW    = 4'h2;
    localparam logic [3:0] OP_ADDI  = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_BNE   = 4'h5;
    localparam logic [3:0] OP_JMP   = 4'h6;

    localparam logic [3:0] FN_ADD = 4'h0;
    localparam logic [3:0] FN_SUB = 4'h1;
    localparam logic [3:0] FN_SLL = 4'h2;
    localparam logic [3:0] FN_AND = 4'h3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DROP  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, hold, flush and valid bit
module if_id_reg
    import proc_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               load,
    input  logic               stall,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [PC_W-1:0]    load_pc,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc,
    output logic [PC_W-1:0]    if_id_pc_plus1
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    // Flush beats load; an unstalled cycle with nothing to load becomes a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_valid    <= 1'b0;
            if_id_instr    <= '0;
            if_id_pc       <= '0;
            if_id_pc_plus1 <= '0;
        end else if (flush) begin
            if_id_valid <= 1'b0;
        end else if (load) begin
            if_id_valid    <= 1'b1;
            if_id_instr    <= load_instr;
            if_id_pc       <= load_pc;
            if_id_pc_plus1 <= load_pc + PC_ONE;
        end else if (!stall) begin
            if_id_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch FSM, pc, one-entry hold buffer and IF/ID register
module fetch_stage
    import proc_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              INSTR_W  = INSTR_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc,
    output logic [PC_W-1:0]    if_id_pc_plus1,
    output logic [3:0]         opcode,
    output logic [3:0]         function_code
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    fetch_state_t       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    drop_addr_q, drop_addr_d;
    logic               hb_valid_q, hb_valid_d;
    logic [INSTR_W-1:0] hb_instr_q, hb_instr_d;
    logic [PC_W-1:0]    hb_pc_q, hb_pc_d;

    logic               flush;
    logic               load;
    logic [INSTR_W-1:0] load_instr;
    logic [PC_W-1:0]    load_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            drop_addr_q <= '0;
            hb_valid_q  <= 1'b0;
            hb_instr_q  <= '0;
            hb_pc_q     <= '0;
        end else begin
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            hb_valid_q  <= hb_valid_d;
            hb_instr_q  <= hb_instr_d;
            hb_pc_q     <= hb_pc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        hb_valid_d  = hb_valid_q;
        hb_instr_d  = hb_instr_q;
        hb_pc_d     = hb_pc_q;
        flush       = 1'b0;
        load        = 1'b0;
        load_instr  = imem_rdata;
        load_pc     = pc_q;

        case (state_q)
            ST_IDLE: begin
                // Any ack seen here belongs to a request abandoned by reset.
                state_d = ST_FETCH;
                if (redirect_valid) begin
                    flush = 1'b1;
                    pc_d  = redirect_pc;
                end
            end
            ST_FETCH: begin
                if (redirect_valid) begin
                    flush      = 1'b1;
                    pc_d       = redirect_pc;
                    hb_valid_d = 1'b0;
                    if (!imem_ack) begin
                        state_d     = ST_DROP;
                        drop_addr_d = pc_q;
                    end
                end else if (imem_ack) begin
                    pc_d = pc_q + PC_ONE;
                    if (!if_id_valid || !stall) begin
                        load = 1'b1;
                    end else begin
                        hb_valid_d = 1'b1;
                        hb_instr_d = imem_rdata;
                        hb_pc_d    = pc_q;
                        state_d    = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    flush      = 1'b1;
                    pc_d       = redirect_pc;
                    hb_valid_d = 1'b0;
                    state_d    = ST_FETCH;
                end else if (!stall) begin
                    load       = hb_valid_q;
                    load_instr = hb_instr_q;
                    load_pc    = hb_pc_q;
                    hb_valid_d = 1'b0;
                    state_d    = ST_FETCH;
                end
            end
            ST_DROP: begin
                // The outstanding response is wrong-path; wait it out, then refetch.
                if (redirect_valid) begin
                    flush = 1'b1;
                    pc_d  = redirect_pc;
                end
                if (imem_ack) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign imem_req  = (state_q == ST_FETCH) || (state_q == ST_DROP);
    assign imem_addr = (state_q == ST_DROP) ? drop_addr_q : pc_q;

    if_id_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_if_id_reg (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .load           (load),
        .stall          (stall),
        .load_instr     (load_instr),
        .load_pc        (load_pc),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus1 (if_id_pc_plus1)
    );

    assign opcode        = if_id_valid ? if_id_instr[OPC_HI:OPC_LO]     : 4'h0;
    assign function_code = if_id_valid ? if_id_instr[FUNCT_HI:FUNCT_LO] : 4'h0;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        if_id_valid;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic [15:0] if_id_pc_plus1;
    logic [3:0]  opcode;
    logic [3:0]  function_code;

    logic        rst2;
    logic        stall2 = 1'b0;
    logic        redirect_valid2 = 1'b0;
    logic [15:0] redirect_pc2 = 16'h0000;
    logic        imem_req2;
    logic [15:0] imem_addr2;
    logic        imem_ack2 = 1'b1;
    logic [15:0] imem_rdata2;
    logic        if_id_valid2;
    logic [15:0] if_id_instr2;
    logic [15:0] if_id_pc2;
    logic [15:0] if_id_pc_plus12;
    logic [3:0]  opcode2;
    logic [3:0]  function_code2;

    int          total = 0;
    int          bad = 0;
    int          ack_mode;
    logic        ack_drv;
    int          wait_cnt;
    logic [15:0] a;

    always #5 clk = ~clk;

    function automatic logic [15:0] word(input logic [15:0] addr);
        return 16'h1000 | {4'h0, addr[11:0]};
    endfunction

    // ack_mode: 0 = tied high, 1 = ack after 3 wait cycles, 2 = driven by ack_drv
    assign imem_ack    = (ack_mode == 0) ? 1'b1 :
                         (ack_mode == 1) ? (imem_req && wait_cnt == 3) : ack_drv;
    assign imem_rdata  = word(imem_addr);
    assign imem_rdata2 = word(imem_addr2);

    always @(posedge clk) begin
        if (ack_mode != 1 || !imem_req || imem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_id_valid(if_id_valid),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_pc_plus1(if_id_pc_plus1),
        .opcode(opcode), .function_code(function_code)
    );

    fetch_stage #(.RESET_PC(16'hFFFE)) dut2 (
        .clk(clk), .rst(rst2), .stall(stall2), .redirect_valid(redirect_valid2),
        .redirect_pc(redirect_pc2), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .if_id_valid(if_id_valid2),
        .if_id_instr(if_id_instr2), .if_id_pc(if_id_pc2), .if_id_pc_plus1(if_id_pc_plus12),
        .opcode(opcode2), .function_code(function_code2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst2 = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 16'h0000; ack_mode = 0; ack_drv = 1'b0;
        step(); step();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req act=%b exp=0", imem_req); end
        total++; if (imem_addr !== 16'h0000) begin bad++; $display("FAIL reset_addr act=%h exp=0000", imem_addr); end
        total++; if ({if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus1} !== 49'h0)
            begin bad++; $display("FAIL reset_ifid act=%b/%h/%h/%h exp=0/0000/0000/0000", if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus1); end
        total++; if ({opcode, function_code} !== 8'h00) begin bad++; $display("FAIL reset_fields act=%h exp=00", {opcode, function_code}); end
        total++; if (imem_addr2 !== 16'hFFFE) begin bad++; $display("FAIL reset_pc2 act=%h exp=fffe", imem_addr2); end
    endtask

    task automatic test_sequential();
        rst = 1'b0;
        step();
        total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL seq_first_valid act=%b exp=0", if_id_valid); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin bad++; $display("FAIL seq_first_req act=%b/%h exp=1/0000", imem_req, imem_addr); end
        for (int k = 0; k < 4; k++) begin
            step();
            total++; if (if_id_valid !== 1'b1 || if_id_pc !== 16'(k))
                begin bad++; $display("FAIL seq_pc%0d act=%b/%h exp=1/%h", k, if_id_valid, if_id_pc, 16'(k)); end
            total++; if (if_id_instr !== 16'h1000 + 16'(k) || opcode !== 4'h1 || function_code !== 4'(k))
                begin bad++; $display("FAIL seq_instr%0d act=%h/%h/%h exp=%h/1/%h", k, if_id_instr, opcode, function_code, 16'h1000 + 16'(k), 4'(k)); end
            total++; if (if_id_pc_plus1 !== 16'(k + 1)) begin bad++; $display("FAIL seq_plus1_%0d act=%h exp=%h", k, if_id_pc_plus1, 16'(k + 1)); end
        end
    endtask

    task automatic test_wait();
        ack_mode = 1;
        for (int r = 0; r < 2; r++) begin
            a = 16'h0004 + 16'(r);
            for (int w = 0; w < 3; w++) begin
                step();
                total++; if (imem_req !== 1'b1 || imem_addr !== a) begin bad++; $display("FAIL wait_addr r%0d w%0d act=%b/%h exp=1/%h", r, w, imem_req, imem_addr, a); end
                total++; if (if_id_valid !== 1'b0 || opcode !== 4'h0) begin bad++; $display("FAIL wait_bubble r%0d w%0d act=%b/%h exp=0/0", r, w, if_id_valid, opcode); end
            end
            step();
            total++; if (if_id_valid !== 1'b1 || if_id_pc !== a || if_id_instr !== word(a))
                begin bad++; $display("FAIL wait_load r%0d act=%b/%h/%h exp=1/%h/%h", r, if_id_valid, if_id_pc, if_id_instr, a, word(a)); end
            total++; if (imem_addr !== a + 16'h1) begin bad++; $display("FAIL wait_next r%0d act=%h exp=%h", r, imem_addr, a + 16'h1); end
        end
    endtask

    task automatic test_redirect_drop();
        ack_mode = 2; ack_drv = 1'b0;
        step();
        total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0006 || if_id_valid !== 1'b0)
            begin bad++; $display("FAIL drop_pre act=%b/%h/%b exp=1/0006/0", imem_req, imem_addr, if_id_valid); end
        redirect_valid = 1'b1; redirect_pc = 16'h0040;
        step();
        redirect_valid = 1'b0;
        for (int w = 0; w < 2; w++) begin
            total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0006 || if_id_valid !== 1'b0)
                begin bad++; $display("FAIL drop_hold w%0d act=%b/%h/%b exp=1/0006/0", w, imem_req, imem_addr, if_id_valid); end
            if (w == 0) step();
        end
        ack_drv = 1'b1;
        step();
        total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040 || if_id_valid !== 1'b0)
            begin bad++; $display("FAIL drop_discard act=%b/%h/%b exp=1/0040/0", imem_req, imem_addr, if_id_valid); end
        step();
        ack_drv = 1'b0;
        total++; if (if_id_valid !== 1'b1 || if_id_pc !== 16'h0040 || if_id_instr !== 16'h1040)
            begin bad++; $display("FAIL drop_target act=%b/%h/%h exp=1/0040/1040", if_id_valid, if_id_pc, if_id_instr); end
    endtask

    task automatic test_redirect_stall();
        stall = 1'b1; ack_drv = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0080;
        step();
        stall = 1'b0; ack_drv = 1'b0; redirect_valid = 1'b0;
        total++; if (if_id_valid !== 1'b0 || {opcode, function_code} !== 8'h00)
            begin bad++; $display("FAIL rs_flush act=%b/%h exp=0/00", if_id_valid, {opcode, function_code}); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0080) begin bad++; $display("FAIL rs_addr act=%b/%h exp=1/0080", imem_req, imem_addr); end
    endtask

    task automatic test_stall_hold();
        ack_drv = 1'b1;
        step();
        total++; if (if_id_valid !== 1'b1 || if_id_pc !== 16'h0080) begin bad++; $display("FAIL sh_load act=%b/%h exp=1/0080", if_id_valid, if_id_pc); end
        stall = 1'b1; ack_drv = 1'b0;
        step();
        ack_drv = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL sh_req c%0d act=%b exp=0", c, imem_req); end
            total++; if (if_id_valid !== 1'b1 || if_id_pc !== 16'h0080 || if_id_instr !== 16'h1080)
                begin bad++; $display("FAIL sh_hold c%0d act=%b/%h/%h exp=1/0080/1080", c, if_id_valid, if_id_pc, if_id_instr); end
        end
        stall = 1'b0;
        step();
        total++; if (if_id_valid !== 1'b1 || if_id_pc !== 16'h0081 || if_id_instr !== 16'h1081)
            begin bad++; $display("FAIL sh_release act=%b/%h/%h exp=1/0081/1081", if_id_valid, if_id_pc, if_id_instr); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0082) begin bad++; $display("FAIL sh_resume act=%b/%h exp=1/0082", imem_req, imem_addr); end
        step();
        total++; if (if_id_pc !== 16'h0082 || if_id_pc_plus1 !== 16'h0083)
            begin bad++; $display("FAIL sh_nodup act=%h/%h exp=0082/0083", if_id_pc, if_id_pc_plus1); end
        ack_drv = 1'b0;
    endtask

    task automatic test_wrap();
        rst2 = 1'b0;
        step();
        total++; if (imem_req2 !== 1'b1 || imem_addr2 !== 16'hFFFE) begin bad++; $display("FAIL wrap_first act=%b/%h exp=1/fffe", imem_req2, imem_addr2); end
        step();
        total++; if (if_id_pc2 !== 16'hFFFE || if_id_pc_plus12 !== 16'hFFFF || imem_addr2 !== 16'hFFFF)
            begin bad++; $display("FAIL wrap_fffe act=%h/%h/%h exp=fffe/ffff/ffff", if_id_pc2, if_id_pc_plus12, imem_addr2); end
        step();
        total++; if (if_id_pc2 !== 16'hFFFF || if_id_pc_plus12 !== 16'h0000 || imem_addr2 !== 16'h0000)
            begin bad++; $display("FAIL wrap_ffff act=%h/%h/%h exp=ffff/0000/0000", if_id_pc2, if_id_pc_plus12, imem_addr2); end
        step();
        total++; if (if_id_pc2 !== 16'h0000 || if_id_pc_plus12 !== 16'h0001 || if_id_instr2 !== 16'h1000)
            begin bad++; $display("FAIL wrap_0000 act=%h/%h/%h exp=0000/0001/1000", if_id_pc2, if_id_pc_plus12, if_id_instr2); end
    endtask

    task automatic test_reset_midwait();
        ack_drv = 1'b0;
        step();
        #3;
        rst = 1'b1;
        #1;
        total++; if (imem_req !== 1'b0 || imem_addr !== 16'h0000) begin bad++; $display("FAIL mid_req act=%b/%h exp=0/0000", imem_req, imem_addr); end
        total++; if ({if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus1, opcode, function_code} !== 57'h0)
            begin bad++; $display("FAIL mid_ifid act=%b/%h/%h/%h exp=0/0000/0000/0000", if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus1); end
        ack_drv = 1'b1;
        step();
        rst = 1'b0;
        step();
        total++; if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0000)
            begin bad++; $display("FAIL mid_idle act=%b/%b/%h exp=0/1/0000", if_id_valid, imem_req, imem_addr); end
        step();
        total++; if (if_id_valid !== 1'b1 || if_id_pc !== 16'h0000) begin bad++; $display("FAIL mid_refetch act=%b/%h exp=1/0000", if_id_valid, if_id_pc); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wait();
        test_redirect_drop();
        test_redirect_stall();
        test_stall_hold();
        test_wrap();
        test_reset_midwait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
